// File: rtl/parity_frame_ctrl.sv
// Frame sequencer around the parity datapath: gathers FRAME_LEN words, compares parity, reports done/error.
// Optional saturating frame-error counter port enabled by defining PARITY_FRAME_ERRCNT_EN.
module parity_frame_ctrl #(
    parameter int DATA_W     = 4,
    parameter int FRAME_LEN  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_start,
    input  logic              in_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_ready,
    input  logic              in_par_valid,
    input  logic              in_par,
    output logic              out_busy,
    output logic [7:0]        out_cnt,
    output logic              out_sum,
    output logic              out_err,
    output logic              out_done
`ifdef PARITY_FRAME_ERRCNT_EN
   ,output logic [7:0]        out_err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, WAIT_PAR, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN);
    localparam logic       ODD_BIT  = 1'(ODD_PARITY);

    state_t     state_q, state_d;
    logic       acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sum_q, sum_d;
    logic       err_q, err_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    state_d = ACCUM;
                    acc_d   = 1'b0;
                    cnt_d   = 8'd0;
                    sum_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ACCUM: begin
                // out_ready is high throughout ACCUM, so in_valid alone means accept.
                if (in_valid) begin
                    acc_d = acc_q ^ (^in_data);
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == LAST_CNT) begin
                        state_d = WAIT_PAR;
                        sum_d   = acc_d ^ ODD_BIT;
                    end
                end
            end
            WAIT_PAR: begin
                if (in_par_valid) begin
                    err_d   = (in_par != sum_q);
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start; status bits keep their last value.
        if (in_abort) begin
            state_d = IDLE;
            acc_d   = acc_q;
            cnt_d   = 8'd0;
            sum_d   = sum_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= 8'd0;
            sum_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    assign out_ready = (state_q == ACCUM);
    assign out_busy  = (state_q != IDLE);
    assign out_done  = (state_q == DONE);
    assign out_cnt   = cnt_q;
    assign out_sum   = sum_q;
    assign out_err   = err_q;

`ifdef PARITY_FRAME_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == DONE && err_q && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed self-checking bench for parity_frame_ctrl (default parameters, 8-word frames, even parity).
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_start, in_abort, in_valid, in_par_valid, in_par;
    logic [3:0] in_data;
    logic       out_ready, out_busy, out_sum, out_err, out_done;
    logic [7:0] out_cnt;
`ifdef PARITY_FRAME_ERRCNT_EN
    logic [7:0] out_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    parity_frame_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_start     (in_start),
        .in_abort     (in_abort),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_ready    (out_ready),
        .in_par_valid (in_par_valid),
        .in_par       (in_par),
        .out_busy     (out_busy),
        .out_cnt      (out_cnt),
        .out_sum      (out_sum),
        .out_err      (out_err),
        .out_done     (out_done)
`ifdef PARITY_FRAME_ERRCNT_EN
       ,.out_err_cnt  (out_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n words; bench counts accepts itself and bounds the loop.
    task automatic feed_words(input logic [3:0] w [8], input int n, input bit stall);
        int k   = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        bit acc;
        while (k < n && cyc < 100) begin
            in_valid = stall ? ph : 1'b1;
            in_data  = w[k];
            ph       = ~ph;
            acc      = in_valid && out_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_accepts", k, n);
    endtask

    task automatic start_frame();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        check("start_busy", out_busy, 1);
        check("start_ready", out_ready, 1);
        check("start_cnt", out_cnt, 0);
        check("start_err_clr", out_err, 0);
    endtask

    // After the last word: deliver parity and check the done pulse and status.
    task automatic finish_frame(input logic par, input logic exp_sum, input logic exp_err);
        check("wait_ready", out_ready, 0);
        check("wait_cnt", out_cnt, 8);
        check("wait_sum", out_sum, exp_sum);
        check("wait_no_done", out_done, 0);
        in_par       = par;
        in_par_valid = 1'b1;
        tick();
        in_par_valid = 1'b0;
        check("done_pulse", out_done, 1);
        check("done_sum", out_sum, exp_sum);
        check("done_err", out_err, exp_err);
        tick();
        check("done_one_cycle", out_done, 0);
        check("back_idle", out_busy, 0);
    endtask

    logic [3:0] w_seq [8];
    logic [3:0] w_f   [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            w_seq[i] = 4'(i + 1);
            w_f[i]   = 4'hF;
        end

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_start     = 1'($urandom);
            in_abort     = 1'($urandom);
            in_valid     = 1'($urandom);
            in_par_valid = 1'($urandom);
            in_par       = 1'($urandom);
            in_data      = 4'($urandom);
            tick();
        end
        check("rst_ready", out_ready, 0);
        check("rst_busy", out_busy, 0);
        check("rst_cnt", out_cnt, 0);
        check("rst_sum", out_sum, 0);
        check("rst_err", out_err, 0);
        check("rst_done", out_done, 0);
`ifdef PARITY_FRAME_ERRCNT_EN
        check("rst_err_cnt", out_err_cnt, 0);
`endif
        in_start = 0; in_abort = 0; in_valid = 0; in_par_valid = 0; in_par = 0; in_data = 0;
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_rst", out_busy, 0);

        // Good frame: words 1..8 have parity 1
        start_frame();
        feed_words(w_seq, 8, 1'b0);
        finish_frame(1'b1, 1'b1, 1'b0);

        // Bad frame
        start_frame();
        feed_words(w_seq, 8, 1'b0);
        finish_frame(1'b0, 1'b1, 1'b1);
`ifdef PARITY_FRAME_ERRCNT_EN
        check("err_cnt_one", out_err_cnt, 1);
`endif
        check("err_holds_idle", out_err, 1);

        // in_valid held in IDLE
        in_valid = 1'b1;
        tick();
        tick();
        check("idle_valid_ready", out_ready, 0);
        check("idle_valid_cnt", out_cnt, 8);
        in_valid = 1'b0;

        // Stalled frame, with in_valid held during WAIT_PAR
        start_frame();
        feed_words(w_seq, 8, 1'b1);
        in_valid = 1'b1;
        tick();
        tick();
        check("waitpar_valid_ready", out_ready, 0);
        check("waitpar_valid_cnt", out_cnt, 8);
        in_valid = 1'b0;
        finish_frame(1'b1, 1'b1, 1'b0);

        // Abort after 3 words
        start_frame();
        feed_words(w_seq, 3, 1'b0);
        check("pre_abort_cnt", out_cnt, 3);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        check("abort_busy", out_busy, 0);
        check("abort_cnt", out_cnt, 0);
        check("abort_done", out_done, 0);
        check("abort_sum_kept", out_sum, 0);
        tick();
        check("abort_no_late_done", out_done, 0);

        // Abort together with start in IDLE
        in_abort = 1'b1;
        in_start = 1'b1;
        tick();
        in_abort = 1'b0;
        in_start = 1'b0;
        check("abort_start_idle", out_busy, 0);

        // Restart with all-0xF words (parity 0)
        start_frame();
        feed_words(w_f, 8, 1'b0);
        finish_frame(1'b0, 1'b0, 1'b0);
`ifdef PARITY_FRAME_ERRCNT_EN
        check("err_cnt_kept", out_err_cnt, 1);
`endif

        // Async reset mid-frame after 5 words
        start_frame();
        feed_words(w_seq, 5, 1'b0);
        check("pre_rst_cnt", out_cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", out_busy, 0);
        check("midrst_ready", out_ready, 0);
        check("midrst_cnt", out_cnt, 0);
`ifdef PARITY_FRAME_ERRCNT_EN
        check("midrst_err_cnt", out_err_cnt, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        start_frame();
        feed_words(w_seq, 8, 1'b0);
        finish_frame(1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
